systolic_feeder: RTL and testbench
==================================

Name: systolic_feeder

Overview:
Upstream input stage for the systolic array of multiply-accumulate elements. It accepts one N×N operand matrix as N vectors over a valid/ready handshake and buffers it. It then streams the matrix into the array edge with diagonal skew, so lane i is delayed i cycles relative to lane 0. One instance feeds the A edge and one feeds the B edge of the array.

Parameters:
data_size, 8, signed element width in bits
array_size, 4, N: number of lanes and number of vectors per matrix (N ≥ 2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
in_data  in  array_size*data_size  input vector; lane i at bits [i*data_size +: data_size]
in_valid  in  1  in_data valid
in_ready  out  1  feeder can accept a vector this cycle
out_data  out  array_size*data_size  skewed lanes to array edge; same packing as in_data
out_lane_valid  out  array_size  per-lane mask: lane carries a real element (not pad)
out_valid  out  1  stream beat present
out_ready  in  1  array advances this cycle; low stalls the stream
done  out  1  one-cycle pulse after the final stream beat is accepted

Behaviour:
- Reset (reset=0, async): state IDLE, counters 0; out_data=0, out_lane_valid=0, out_valid=0, done=0, in_ready=0.
- After reset deasserts, in_ready=1.
- States: IDLE, LOAD, STREAM.
- IDLE/LOAD:
  - in_ready=1.
  - On each accept (in_valid & in_ready), store the vector in buffer row wr_ptr, then wr_ptr++.
  - The first accept moves IDLE→LOAD.
  - The accept with wr_ptr==N-1 moves to STREAM and clears wr_ptr.
- STREAM:
  - in_ready=0.
  - Step counter t runs 0..2N-2; counter width $clog2(2N).
  - Beat t (registered outputs): lane i = buffer[t-i][i] when 0 ≤ t-i < N, else 0.
  - out_lane_valid[i] is set exactly when the lane is in that window.
  - out_valid=1 for all 2N-1 beats.
  - First beat is valid on the cycle after the Nth accept (1-cycle latency).
- Advance/stall:
  - t advances only when out_valid & out_ready.
  - When out_ready=0, out_data, out_lane_valid and out_valid hold unchanged.
  - No beat is skipped or repeated.
- End of stream: on acceptance of beat 2N-2, next cycle out_valid=0, out_data=0, out_lane_valid=0, done=1 for exactly one cycle, and state returns to IDLE (in_ready=1 that same cycle).
- Data is passed bit-exact. No arithmetic on elements; signed values including -2^(data_size-1) are unchanged.
- If in_valid is asserted while in_ready=0, the input is ignored and not stored.
- Reset asserted mid-LOAD or mid-STREAM: immediate return to reset values; partial matrix discarded.

Optional Feature:
Macro FEEDER_PINGPONG_EN.
- Defined:
  - Two buffer banks; in_ready stays 1 during STREAM while the idle bank is not full, and accepts fill the idle bank.
  - If the idle bank is full when the final beat is accepted, done pulses and streaming of that bank starts on the next cycle with t=0 (no IDLE bubble); the outgoing bank becomes the fill bank.
  - A full idle bank holds in_ready=0 until the swap.
- Undefined: single bank, behaviour exactly as above.

Decomposition:
- Shared package/header: lane-packing macro/function, STEP_W = $clog2(2*array_size), PTR_W = $clog2(array_size), state encodings (IDLE=0, LOAD=1, STREAM=2).
- One natural sub-module: feeder_bank, an N×N register file with a write port (row index, vector) and combinational read of any element. It is instantiated once, or twice under FEEDER_PINGPONG_EN.
- FSM, counters and skew mux stay in systolic_feeder.

Test Plan:
- N=4, data_size=8; load rows [1,2,3,4],[5,6,7,8],[9,10,11,12],[13,14,15,16] with out_ready=1 → beat0 lanes (1,0,0,0) mask 0001; beat1 (5,2,0,0); beat3 (13,10,7,4) mask 1111; beat6 (0,0,0,16) mask 1000; 7 beats total; done pulses once on the following cycle; in_ready=1 that cycle.
- Same matrix, out_ready=0 for 3 cycles at beat2 → outputs hold (9,6,3,0) for 4 cycles, then sequence resumes at beat3 with no loss or duplication.
- in_valid gaps during LOAD (valid on alternating cycles) → same 7-beat output as the first test. in_valid held high during STREAM → ignored (single-bank build), next matrix is loaded only after done.
- Rows containing -128 and 127 → values emerge bit-exact on the correct lanes and beats; pad lanes read 0.
- Drive reset low after 2 accepts, and separately at beat 3 → all outputs 0 immediately, in_ready=1 after release; a fresh full load then streams correctly.
- FEEDER_PINGPONG_EN: load matrix M1, then load M2 during M1's stream → M2 beat0 appears the cycle after M1's final beat. done pulses between the two streams; out_valid has no low cycle.

Source files
------------

// File: rtl/systolic_feeder_pkg.sv
// Shared types and width helpers for the systolic array edge feeder.
package systolic_feeder_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLoad   = 2'd1,
    StStream = 2'd2
  } feeder_state_e;

  // Step counter covers beats 0..2N-2.
  function automatic int unsigned step_width(input int unsigned n);
    return $clog2(2 * n);
  endfunction

  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/systolic_feeder_bank.sv
// NxN operand buffer: one row write port, per-lane combinational element read.
module systolic_feeder_bank
  import systolic_feeder_pkg::*;
#(
  parameter int unsigned data_size  = 8,
  parameter int unsigned array_size = 4,
  localparam int unsigned PTR_W     = ptr_width(array_size),
  localparam int unsigned VEC_W     = array_size * data_size
) (
  input  logic                        clk,
  input  logic                        i_wr_en,
  input  logic [PTR_W-1:0]            i_wr_row,
  input  logic [VEC_W-1:0]            i_wr_vec,
  input  logic [array_size*PTR_W-1:0] i_rd_rows,
  output logic [VEC_W-1:0]            o_rd_vec
);

  logic [VEC_W-1:0] r_mem [array_size];

  // Contents need no reset: lanes are only read after their row has been written.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_row] <= i_wr_vec;
    end
  end

  always_comb begin
    o_rd_vec = '0;
    for (int i = 0; i < int'(array_size); i++) begin
      o_rd_vec[lane_lsb(i, data_size) +: data_size] =
          r_mem[i_rd_rows[i*PTR_W +: PTR_W]][lane_lsb(i, data_size) +: data_size];
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Skewed systolic-array edge feeder: buffers an NxN matrix, then streams lane i delayed i beats.
// Define FEEDER_PINGPONG_EN for a second bank that fills while the other bank streams.
module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int unsigned data_size  = 8,
  parameter int unsigned array_size = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [array_size*data_size-1:0] in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [array_size*data_size-1:0] out_data,
  output logic [array_size-1:0]           out_lane_valid,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            done
);

  localparam int unsigned VEC_W   = array_size * data_size;
  localparam int unsigned STEP_W  = step_width(array_size);
  localparam int unsigned PTR_W   = ptr_width(array_size);
  localparam logic [STEP_W-1:0] LastStep = STEP_W'(2 * array_size - 2);
  localparam logic [PTR_W-1:0]  LastRow  = PTR_W'(array_size - 1);

  feeder_state_e               r_state, w_state_d;
  logic [PTR_W-1:0]            r_wr_ptr, w_wr_ptr_d;
  logic [STEP_W-1:0]           r_t, w_t_d;
  logic [VEC_W-1:0]            r_out_data;
  logic [array_size-1:0]       r_out_lane_valid;
  logic                        r_out_valid, r_done, r_live;
  logic                        w_accept, w_last_row, w_adv, w_last_beat;
  logic                        w_load_beat, w_clear, w_done_d;
  logic [array_size*PTR_W-1:0] w_rd_rows;
  logic [array_size-1:0]       w_beat_mask;
  logic [VEC_W-1:0]            w_src_vec, w_beat_data;

  assign w_accept    = in_valid & in_ready;
  assign w_last_row  = w_accept & (r_wr_ptr == LastRow);
  assign w_adv       = r_out_valid & out_ready;
  assign w_last_beat = w_adv & (r_t == LastStep);

`ifdef FEEDER_PINGPONG_EN
  logic             r_wr_bank, w_wr_bank_d, r_rd_bank, w_rd_bank_d;
  logic             r_pend, w_pend_d, w_src_bank;
  logic [VEC_W-1:0] w_rd_vec0, w_rd_vec1;

  // r_pend: the fill bank holds a complete matrix waiting for the stream bank to drain.
  assign in_ready = r_live & ~r_pend;
`else
  assign in_ready = r_live & (r_state != StStream);
`endif

  always_comb begin
    w_state_d   = r_state;
    w_wr_ptr_d  = r_wr_ptr;
    w_t_d       = r_t;
    w_load_beat = 1'b0;
    w_clear     = 1'b0;
    w_done_d    = 1'b0;
`ifdef FEEDER_PINGPONG_EN
    w_wr_bank_d = r_wr_bank;
    w_rd_bank_d = r_rd_bank;
    w_pend_d    = r_pend;
    w_src_bank  = r_rd_bank;
`endif
    if (w_accept) begin
      w_wr_ptr_d = w_last_row ? '0 : r_wr_ptr + 1'b1;
    end
    unique case (r_state)
      StIdle, StLoad: begin
        if (w_accept) begin
          w_state_d = StLoad;
          if (w_last_row) begin
            w_state_d   = StStream;
            w_t_d       = '0;
            w_load_beat = 1'b1;
`ifdef FEEDER_PINGPONG_EN
            w_src_bank  = r_wr_bank;
            w_rd_bank_d = r_wr_bank;
            w_wr_bank_d = ~r_wr_bank;
`endif
          end
        end
      end
      StStream: begin
`ifdef FEEDER_PINGPONG_EN
        w_pend_d = r_pend | w_last_row;
`endif
        if (w_last_beat) begin
          w_done_d = 1'b1;
`ifdef FEEDER_PINGPONG_EN
          // Back-to-back swap: the full fill bank streams next with no idle beat.
          if (r_pend | w_last_row) begin
            w_t_d       = '0;
            w_load_beat = 1'b1;
            w_src_bank  = r_wr_bank;
            w_rd_bank_d = r_wr_bank;
            w_wr_bank_d = r_rd_bank;
            w_pend_d    = 1'b0;
          end else
`endif
          begin
            w_state_d = (w_wr_ptr_d != '0) ? StLoad : StIdle;
            w_t_d     = '0;
            w_clear   = 1'b1;
          end
        end else if (w_adv) begin
          w_t_d       = r_t + 1'b1;
          w_load_beat = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Lane i at step t reads row t-i while that row index is inside the matrix.
  always_comb begin
    w_rd_rows   = '0;
    w_beat_mask = '0;
    for (int i = 0; i < int'(array_size); i++) begin
      if ((int'(w_t_d) >= i) && ((int'(w_t_d) - i) < int'(array_size))) begin
        w_beat_mask[i]              = 1'b1;
        w_rd_rows[i*PTR_W +: PTR_W] = PTR_W'(int'(w_t_d) - i);
      end
    end
  end

  always_comb begin
    w_beat_data = '0;
    for (int i = 0; i < int'(array_size); i++) begin
      if (w_beat_mask[i]) begin
        w_beat_data[lane_lsb(i, data_size) +: data_size] =
            w_src_vec[lane_lsb(i, data_size) +: data_size];
      end
    end
  end

`ifdef FEEDER_PINGPONG_EN
  systolic_feeder_bank #(
    .data_size  (data_size),
    .array_size (array_size)
  ) u_bank0 (
    .clk       (clk),
    .i_wr_en   (w_accept & ~r_wr_bank),
    .i_wr_row  (r_wr_ptr),
    .i_wr_vec  (in_data),
    .i_rd_rows (w_rd_rows),
    .o_rd_vec  (w_rd_vec0)
  );

  systolic_feeder_bank #(
    .data_size  (data_size),
    .array_size (array_size)
  ) u_bank1 (
    .clk       (clk),
    .i_wr_en   (w_accept & r_wr_bank),
    .i_wr_row  (r_wr_ptr),
    .i_wr_vec  (in_data),
    .i_rd_rows (w_rd_rows),
    .o_rd_vec  (w_rd_vec1)
  );

  assign w_src_vec = w_src_bank ? w_rd_vec1 : w_rd_vec0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_pend    <= 1'b0;
    end else begin
      r_wr_bank <= w_wr_bank_d;
      r_rd_bank <= w_rd_bank_d;
      r_pend    <= w_pend_d;
    end
  end
`else
  systolic_feeder_bank #(
    .data_size  (data_size),
    .array_size (array_size)
  ) u_bank (
    .clk       (clk),
    .i_wr_en   (w_accept),
    .i_wr_row  (r_wr_ptr),
    .i_wr_vec  (in_data),
    .i_rd_rows (w_rd_rows),
    .o_rd_vec  (w_src_vec)
  );
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state          <= StIdle;
      r_wr_ptr         <= '0;
      r_t              <= '0;
      r_out_data       <= '0;
      r_out_lane_valid <= '0;
      r_out_valid      <= 1'b0;
      r_done           <= 1'b0;
      r_live           <= 1'b0;
    end else begin
      r_live   <= 1'b1;
      r_state  <= w_state_d;
      r_wr_ptr <= w_wr_ptr_d;
      r_t      <= w_t_d;
      r_done   <= w_done_d;
      if (w_load_beat) begin
        r_out_data       <= w_beat_data;
        r_out_lane_valid <= w_beat_mask;
        r_out_valid      <= 1'b1;
      end else if (w_clear) begin
        r_out_data       <= '0;
        r_out_lane_valid <= '0;
        r_out_valid      <= 1'b0;
      end
    end
  end

  assign out_data       = r_out_data;
  assign out_lane_valid = r_out_lane_valid;
  assign out_valid      = r_out_valid;
  assign done           = r_done;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed, table-driven bench for systolic_feeder (N=4, 8-bit elements).
module tb_systolic_feeder;

  localparam int unsigned DS = 8;
  localparam int unsigned N  = 4;
  localparam int unsigned W  = N * DS;

`ifdef FEEDER_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  typedef logic [W-1:0] mat_t [N];
  typedef struct packed {
    logic [W-1:0] data;
    logic [N-1:0] mask;
  } beat_t;
  typedef struct {
    logic         out_ready;
    logic [W-1:0] data;
    logic [N-1:0] mask;
    logic         valid;
    logic         done;
    logic         ready;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic [N-1:0] out_lane_valid;
  logic         out_valid;
  logic         out_ready;
  logic         done;

  int    n_checks = 0;
  int    n_errors = 0;
  mat_t  m1, me;
  beat_t exp_m1 [7];
  beat_t exp_e  [7];
  vec_t  tab [$];

  always #5 clk = ~clk;

  systolic_feeder #(
    .data_size  (DS),
    .array_size (N)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_data       (out_data),
    .out_lane_valid (out_lane_valid),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .done           (done)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", nm, got, exp);
    end
  endtask

  task automatic chk_beat(input string nm, input logic [W-1:0] d, input logic [N-1:0] m,
                          input logic v, input logic dn, input logic rdy);
    chk({nm, ".data"}, out_data, d);
    chk({nm, ".mask"}, 32'(out_lane_valid), 32'(m));
    chk({nm, ".valid"}, 32'(out_valid), 32'(v));
    chk({nm, ".done"}, 32'(done), 32'(dn));
    chk({nm, ".in_ready"}, 32'(in_ready), 32'(rdy));
  endtask

  // Leaves the bench on the negedge after the Nth accept, where beat 0 must be visible.
  task automatic load(input mat_t m, input bit gaps);
    for (int r = 0; r < int'(N); r++) begin
      chk($sformatf("load_ready[%0d]", r), 32'(in_ready), 32'd1);
      in_data  = m[r];
      in_valid = 1'b1;
      @(negedge clk);
      if (gaps && r < int'(N) - 1) begin
        in_valid = 1'b0;
        in_data  = 32'hA5A5A5A5;
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic build(input beat_t b [7], input int stall_at, input int stall_len);
    tab.delete();
    for (int k = 0; k < 7; k++) begin
      if (k == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          tab.push_back('{1'b0, b[k].data, b[k].mask, 1'b1, 1'b0, PP});
        end
      end
      tab.push_back('{1'b1, b[k].data, b[k].mask, 1'b1, 1'b0, PP});
    end
    tab.push_back('{1'b1, '0, '0, 1'b0, 1'b1, 1'b1});
  endtask

  task automatic run_tab(input string nm, input bit hold_junk);
    if (hold_junk) begin
      in_valid = 1'b1;
      in_data  = 32'hDEADBEEF;
    end
    for (int k = 0; k < tab.size(); k++) begin
      chk_beat($sformatf("%s[%0d]", nm, k), tab[k].data, tab[k].mask, tab[k].valid,
               tab[k].done, tab[k].ready);
      out_ready = tab[k].out_ready;
      if (k == tab.size() - 1) in_valid = 1'b0;
      @(negedge clk);
    end
    chk({nm, ".done_low"}, 32'(done), 32'd0);
    chk({nm, ".valid_low"}, 32'(out_valid), 32'd0);
    out_ready = 1'b1;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, ".data"}, out_data, 32'd0);
    chk({nm, ".mask"}, 32'(out_lane_valid), 32'd0);
    chk({nm, ".valid"}, 32'(out_valid), 32'd0);
    chk({nm, ".done"}, 32'(done), 32'd0);
    chk({nm, ".in_ready"}, 32'(in_ready), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    m1[0] = 32'h04030201;
    m1[1] = 32'h08070605;
    m1[2] = 32'h0C0B0A09;
    m1[3] = 32'h100F0E0D;
    exp_m1[0] = '{32'h00000001, 4'b0001};
    exp_m1[1] = '{32'h00000205, 4'b0011};
    exp_m1[2] = '{32'h00030609, 4'b0111};
    exp_m1[3] = '{32'h04070A0D, 4'b1111};
    exp_m1[4] = '{32'h080B0E00, 4'b1110};
    exp_m1[5] = '{32'h0C0F0000, 4'b1100};
    exp_m1[6] = '{32'h10000000, 4'b1000};
    // Extremes: -128 = 8'h80, 127 = 8'h7F; lane 0 of beat 2 is a real zero element.
    me[0] = 32'hFF017F80;
    me[1] = 32'h02FE807F;
    me[2] = 32'h7F801100;
    me[3] = 32'h807F807F;
    exp_e[0] = '{32'h00000080, 4'b0001};
    exp_e[1] = '{32'h00007F7F, 4'b0011};
    exp_e[2] = '{32'h00018000, 4'b0111};
    exp_e[3] = '{32'hFFFE117F, 4'b1111};
    exp_e[4] = '{32'h02808000, 4'b1110};
    exp_e[5] = '{32'h7F7F0000, 4'b1100};
    exp_e[6] = '{32'h80000000, 4'b1000};

    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset("por");
    reset = 1'b1;
    @(negedge clk);
    chk("por.in_ready_after", 32'(in_ready), 32'd1);

    load(m1, 1'b0);
    build(exp_m1, -1, 0);
    run_tab("basic", 1'b0);

    load(m1, 1'b0);
    build(exp_m1, 2, 3);
    run_tab("stall", 1'b0);

    load(m1, 1'b1);
    build(exp_m1, -1, 0);
    run_tab("gaps", !PP);
    load(m1, 1'b0);
    build(exp_m1, -1, 0);
    run_tab("after_junk", 1'b0);

    load(me, 1'b0);
    build(exp_e, -1, 0);
    run_tab("extreme", 1'b0);

    for (int r = 0; r < 2; r++) begin
      in_data  = me[r];
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    reset    = 1'b0;
    #1;
    chk_reset("rst_load");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_load.in_ready_after", 32'(in_ready), 32'd1);
    load(m1, 1'b0);
    build(exp_m1, -1, 0);
    run_tab("after_rst_load", 1'b0);

    load(m1, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_stream.beat3", out_data, exp_m1[3].data);
    reset = 1'b0;
    #1;
    chk_reset("rst_stream");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_stream.in_ready_after", 32'(in_ready), 32'd1);
    load(me, 1'b0);
    build(exp_e, -1, 0);
    run_tab("after_rst_stream", 1'b0);

`ifdef FEEDER_PINGPONG_EN
    load(m1, 1'b0);
    for (int k = 0; k < 7; k++) begin
      chk_beat($sformatf("pp_m1[%0d]", k), exp_m1[k].data, exp_m1[k].mask, 1'b1, 1'b0, k < 4);
      if (k < 4) begin
        in_valid = 1'b1;
        in_data  = me[k];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    for (int k = 0; k < 7; k++) begin
      chk_beat($sformatf("pp_e[%0d]", k), exp_e[k].data, exp_e[k].mask, 1'b1, k == 0, 1'b1);
      @(negedge clk);
    end
    chk_beat("pp_done", '0, '0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("pp.done_low", 32'(done), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
